// File: rtl/fetch_stage.sv
// fetch_stage: PC register and registered instruction slot feeding decode.
// Ports: clk, rst (sync, active-high); imem_addr/imem_data to the
// instruction memory (combinational read); redirect_valid/redirect_target
// from branch resolution; id_ready/id_valid/id_instr/id_pc handshake to
// decode; fault is a sticky misaligned-fetch flag, cleared only by rst.
module fetch_stage #(
  parameter logic [47:0] RESET_VECTOR = 48'h0000_0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [47:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [47:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [47:0] id_pc,
  output logic        fault
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [47:0] pc;
  logic [47:0] pc_nxt;
  logic        valid;
  logic        valid_nxt;
  logic [31:0] instr;
  logic [31:0] instr_nxt;
  logic [47:0] ipc;
  logic [47:0] ipc_nxt;
  logic        flt;
  logic        flt_nxt;

  logic slot_free;
  logic redir_bad;
  logic redir_ok;
  logic do_fetch;

  // Decode the per-cycle action into mutually exclusive terms so the
  // priority (bad redirect > redirect > fetch > stall) is explicit.
  assign slot_free = !valid || id_ready;
  assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign do_fetch  = !redirect_valid && slot_free;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = valid;
    instr_nxt = instr;
    ipc_nxt   = ipc;
    flt_nxt   = flt;
    if (state == RUN) begin
      unique case (1'b1)
        redir_bad: begin
          state_nxt = FAULT;
          flt_nxt   = 1'b1;
          pc_nxt    = redirect_target;
          valid_nxt = 1'b0;
          instr_nxt = NOP_INSTR;
        end
        redir_ok: begin
          pc_nxt    = redirect_target;
          valid_nxt = 1'b0;
          instr_nxt = NOP_INSTR;
        end
        do_fetch: begin
          instr_nxt = imem_data;
          ipc_nxt   = pc;
          valid_nxt = 1'b1;
          // 48-bit add wraps naturally at the top of the space
          pc_nxt    = pc + 48'd4;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
      valid <= 1'b0;
      instr <= NOP_INSTR;
      ipc   <= 48'h0;
      flt   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      valid <= valid_nxt;
      instr <= instr_nxt;
      ipc   <= ipc_nxt;
      flt   <= flt_nxt;
    end
  end

  assign imem_addr = pc;
  assign id_valid  = valid;
  assign id_instr  = instr;
  assign id_pc     = ipc;
  assign fault     = flt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic for
// fetch_stage, checked against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [47:0] RV  = 48'h0000_0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [47:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [47:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [47:0] id_pc;
  logic        fault;

  int n_checks;
  int n_fail;

  // model state
  logic [47:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [47:0] m_idpc;
  logic        m_fault;

  fetch_stage #(
    .RESET_VECTOR(RV),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [47:0] a);
    logic [31:0] w;
    w = a[33:2] * 32'h9E37_79B1;
    return (w + 32'h1234_5677) ^ {16'h0, a[47:32]};
  endfunction

  assign imem_data = memf(imem_addr);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the fetch rules, in plain terms.
  task automatic model_edge(input logic r, input logic rv,
                            input logic [47:0] rt, input logic rdy);
    if (r) begin
      m_pc = RV; m_fault = 1'b0; m_valid = 1'b0;
      m_instr = NOP; m_idpc = 48'h0;
    end else if (m_fault) begin
      // frozen until reset
    end else if (rv) begin
      m_pc = rt; m_valid = 1'b0; m_instr = NOP;
      if (rt[1:0] != 2'b00) m_fault = 1'b1;
    end else if (!m_valid || rdy) begin
      m_instr = memf(m_pc);
      m_idpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 48'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(id_valid), 64'(m_valid));
    check({tag, ".instr"}, 64'(id_instr), 64'(m_instr));
    check({tag, ".idpc"},  64'(id_pc),    64'(m_idpc));
    check({tag, ".addr"},  64'(imem_addr), 64'(m_pc));
    check({tag, ".fault"}, 64'(fault),    64'(m_fault));
  endtask

  // Called at a falling edge: drive, clock, then compare at next fall.
  task automatic step(input string tag, input logic r, input logic rv,
                      input logic [47:0] rt, input logic rdy);
    rst = r; redirect_valid = rv;
    redirect_target = rt; id_ready = rdy;
    @(posedge clk);
    model_edge(r, rv, rt, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic r;
    logic rv;
    logic rdy;
    logic [47:0] rt;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; redirect_valid = 1'b0;
    redirect_target = 48'h0; id_ready = 1'b0;
    @(negedge clk);
    step("rst0", 1, 0, 48'h0, 0);
    step("rst1", 1, 1, 48'h40, 1);
    check("rst_idpc", 64'(id_pc), 64'h0);
    check("rst_instr", 64'(id_instr), 64'(NOP));

    // streaming: id_pc 0,4,8 back to back
    step("str1", 0, 0, 48'h0, 1);
    check("str1_pc", 64'(id_pc), 64'h0);
    step("str2", 0, 0, 48'h0, 1);
    check("str2_pc", 64'(id_pc), 64'h4);
    step("str3", 0, 0, 48'h0, 1);
    check("str3_pc", 64'(id_pc), 64'h8);
    check("str3_ins", 64'(id_instr), 64'(memf(48'h8)));

    // stall three cycles holding 0x8, then release
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 48'h0, 0);
    check("stall_pc", 64'(id_pc), 64'h8);
    check("stall_addr", 64'(imem_addr), 64'hC);
    step("rel", 0, 0, 48'h0, 1);
    check("rel_pc", 64'(id_pc), 64'hC);

    // redirect during a stall
    step("st", 0, 0, 48'h0, 0);
    step("redir", 0, 1, 48'h100, 0);
    check("redir_v", 64'(id_valid), 64'h0);
    check("redir_a", 64'(imem_addr), 64'h100);
    step("redir2", 0, 0, 48'h0, 1);
    check("redir2_pc", 64'(id_pc), 64'h100);

    // wrap at the top of the address space
    step("wr0", 0, 1, 48'hFFFF_FFFF_FFFC, 1);
    step("wr1", 0, 0, 48'h0, 1);
    check("wr1_pc", 64'(id_pc), 64'hFFFF_FFFF_FFFC);
    step("wr2", 0, 0, 48'h0, 1);
    check("wr2_pc", 64'(id_pc), 64'h0);

    // misaligned redirect, ignored redirect, recovery by reset
    step("mis", 0, 1, 48'h102, 1);
    check("mis_f", 64'(fault), 64'h1);
    check("mis_a", 64'(imem_addr), 64'h102);
    step("mis2", 0, 1, 48'h200, 1);
    step("mis3", 0, 0, 48'h0, 1);
    check("mis3_a", 64'(imem_addr), 64'h102);
    step("misr", 1, 0, 48'h0, 1);
    check("misr_f", 64'(fault), 64'h0);

    // reset during a stall with a valid instruction held
    step("f0", 0, 0, 48'h0, 1);
    step("f1", 0, 0, 48'h0, 0);
    step("rs", 1, 1, 48'h300, 0);
    check("rs_v", 64'(id_valid), 64'h0);
    check("rs_pc", 64'(id_pc), 64'h0);
    check("rs_a", 64'(imem_addr), 64'(RV));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0) ||
            (m_fault && $urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: rt = {$urandom, $urandom} | 48'h1;
        1: rt = 48'hFFFF_FFFF_FFF0 | 48'($urandom_range(0, 3) * 4);
        default: rt = {$urandom, $urandom} & ~48'h3;
      endcase
      step("rnd", r, rv, rt, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
